st_burst_ctrl: RTL and testbench
================================

# st_burst_ctrl

Strobe scheduler for the Lab412L strobe path. It owns a programmable period counter and grants it to one of two requesters at a time under round-robin arbitration. Each granted requester receives a burst of `len` one-clock strobes on `st`, spaced `period` clocks apart, followed by a `done` pulse. It sits between the lab's consumer blocks (serial shifters, display scanners) and the strobe generator they previously instantiated privately.

## Interface
- `PRD_W`, 16: width of period inputs and the period counter.
- `LEN_W`, 8: width of burst length inputs and the burst counter.

- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 2: burst request, one bit per requester; level, held until `done`.
- `prd0`, `prd1` in PRD_W: strobe period for requester 0/1; sampled at grant.
- `len0`, `len1` in LEN_W: strobes per burst for requester 0/1; sampled at grant.
- `gnt` out 2: one-hot grant; zero when idle.
- `st` out 1: strobe, one clock wide.
- `busy` out 1: high in RUN and DONE.
- `done` out 2: one-clock completion pulse to the granted requester.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE, `gnt`=0, `st`=0, `busy`=0, `done`=0, counters 0, priority pointer selects requester 0.
- IDLE: if `req`≠0, grant per round-robin.
  - Both requesting: the requester not served last wins.
  - After reset: requester 0 wins.
  - On grant, latch `prd`/`len` of the winner and set the pointer so the winner becomes lowest priority.
  - Latched period 0 is treated as 1.
  - Latched `len`=0: go straight to DONE; no strobes.
  - Otherwise go to RUN with the period counter cleared.
- RUN: the period counter counts 0..P-1 and wraps.
  - `st`=1 in the cycle the counter equals P-1.
  - The burst counter increments on each `st`.
  - The cycle the burst counter reaches `len`, the next state is DONE.
- DONE: one cycle. `done[g]`=1, `gnt` still asserted. Next state is IDLE with `gnt` cleared.
- Abort: the granted `req` bit goes low in RUN.
  - Next edge goes to IDLE; no `done`.
  - A strobe already due in that same cycle is still emitted.
  - The pointer keeps its grant-time update.
- Config inputs changing during RUN have no effect; latched values are used.
- Non-granted `req` changes during RUN/DONE are ignored until IDLE.
- `rst` asserted mid-burst clears everything immediately: no `st` or `done` glitch after assertion.

## Timing
- All outputs are registered.
- `req` high in IDLE at edge k: `gnt` and `busy` high from edge k+1.
- First `st` in the P-th cycle after entering RUN. Strobe j (1-based) occurs at edge k+1+j·P.
- `done` in the cycle after the last strobe.
- `gnt` drops, and IDLE is re-entered, one cycle after `done`.
- Burst occupancy: 1+len·P+1 cycles from `gnt` rise to IDLE. A new grant can occur the edge after IDLE is re-entered, so there is one idle cycle minimum between bursts.
- P=1: `st` high on every RUN cycle.
- Counter widths wrap only via the reload logic; the period counter never exceeds P-1.

## Structure
- Package `st_ctrl_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - default widths `PRD_W`/`LEN_W`;
  - requester-count constant 2.
- Sub-module `st_tick`: the period counter with clear, enable and period input, producing a one-cycle tick at P-1.
- Arbitration, burst counting and the FSM stay in the top-level module.

## Test plan
- Single burst: `req0`=1, `prd0`=4, `len0`=3.
  - `gnt`=01 at edge 1.
  - `st` at edges 5, 9, 13; `done`=01 at 14; `gnt`=00 at 15.
- Contention: `req`=11 from reset with `len0`=`len1`=2, `prd`=2.
  - Requester 0 served first, then requester 1.
  - Re-raising both afterwards serves 0 again, because 1 was served last.
- Zero length / P=1:
  - `len1`=0 gives `gnt`=10, then `done`=10 with no `st`.
  - `prd0`=0, `len0`=4 gives `st` high for 4 consecutive cycles.
- Abort: `prd0`=10, `len0`=5; drop `req0` after the 2nd strobe.
  - IDLE next edge; no `done`; exactly 2 strobes observed.
- Reset mid-burst: assert `rst` between edges during RUN.
  - All outputs 0 immediately.
  - After release, the next grant goes to requester 0.
- Config change: alter `prd0` from 3 to 7 during RUN.
  - Strobe spacing stays 3 until `done`.

Source files
------------

// File: rtl/st_ctrl_pkg.sv
// Shared types and constants for the strobe burst scheduler.
package st_ctrl_pkg;

  localparam int DEFAULT_PRD_W = 16;
  localparam int DEFAULT_LEN_W = 8;
  localparam int NUM_REQ       = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot grant/done vector for a requester index.
  function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/st_tick.sv
// Period counter: counts 0..prd-1 while enabled and flags the last count.
module st_tick
  import st_ctrl_pkg::*;
#(
  parameter int PRD_W = DEFAULT_PRD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [PRD_W-1:0] prd,
  output logic             tick
);

  localparam logic [PRD_W-1:0] ONE = PRD_W'(1);

  logic [PRD_W-1:0] cnt;
  logic             at_end;

  // The caller guarantees prd >= 1, so the counter never exceeds prd-1.
  assign at_end = (cnt == (prd - ONE));
  assign tick   = en & at_end;

  // Count while enabled, wrapping at prd-1; clear has priority.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_end ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/st_burst_ctrl.sv
// Round-robin strobe burst scheduler: grants one of two requesters a burst
// of len strobes spaced period clocks apart, then pulses done.
module st_burst_ctrl
  import st_ctrl_pkg::*;
#(
  parameter int PRD_W = DEFAULT_PRD_W,
  parameter int LEN_W = DEFAULT_LEN_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [PRD_W-1:0]   prd0,
  input  logic [PRD_W-1:0]   prd1,
  input  logic [LEN_W-1:0]   len0,
  input  logic [LEN_W-1:0]   len1,
  output logic [NUM_REQ-1:0] gnt,
  output logic               st,
  output logic               busy,
  output logic [NUM_REQ-1:0] done
);

  localparam logic [PRD_W-1:0] PRD_ONE = PRD_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state;
  logic             prio;      // requester that wins when both ask
  logic             sel;       // requester currently granted
  logic [PRD_W-1:0] prd_l;
  logic [LEN_W-1:0] len_l;
  logic [LEN_W-1:0] bcnt;

  logic             win;
  logic [PRD_W-1:0] win_prd;
  logic [LEN_W-1:0] win_len;
  logic             burst_end;
  logic             tick;
  logic             tick_en;
  logic             tick_clr;

  // With both requesting the pointer decides; otherwise the lone requester wins.
  assign win     = (&req) ? prio : req[1];
  assign win_prd = win ? prd1 : prd0;
  assign win_len = win ? len1 : len0;

  // Once the last strobe is issued the period counter stops so no extra tick appears.
  assign burst_end = (bcnt == len_l);
  assign tick_en   = (state == RUN) && !burst_end;
  assign tick_clr  = (state == IDLE);

  st_tick #(
    .PRD_W(PRD_W)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (tick_clr),
    .en  (tick_en),
    .prd (prd_l),
    .tick(tick)
  );

  // Scheduler FSM with registered gnt/st/busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      st    <= 1'b0;
      busy  <= 1'b0;
      done  <= '0;
      prio  <= 1'b0;
      sel   <= 1'b0;
      prd_l <= '0;
      len_l <= '0;
      bcnt  <= '0;
    end else begin
      // Pulses default low and are raised only by the branch that owns them.
      st   <= 1'b0;
      done <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= req_onehot(win);
            busy  <= 1'b1;
            sel   <= win;
            prio  <= ~win;
            prd_l <= (win_prd == '0) ? PRD_ONE : win_prd;
            len_l <= win_len;
            bcnt  <= '0;
            if (win_len == '0) begin
              state <= DONE;
              done  <= req_onehot(win);
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          st <= tick;
          if (tick) begin
            bcnt <= bcnt + LEN_ONE;
          end
          if (!req[sel]) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end else if (burst_end) begin
            state <= DONE;
            done  <= gnt;
          end
        end
        DONE: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_st_burst_ctrl.sv
// Directed bench for st_burst_ctrl: table of single bursts plus hand-written
// contention, abort, reset and config-change sequences.
module tb_st_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] prd0, prd1;
  logic [7:0]  len0, len1;
  logic [1:0]  gnt;
  logic        st;
  logic        busy;
  logic [1:0]  done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  st_burst_ctrl dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .prd0(prd0),
    .prd1(prd1),
    .len0(len0),
    .len1(len1),
    .gnt (gnt),
    .st  (st),
    .busy(busy),
    .done(done)
  );

  typedef struct {
    logic [1:0]  req;
    logic [15:0] prd0;
    logic [7:0]  len0;
    logic [15:0] prd1;
    logic [7:0]  len1;
    logic [1:0]  exp_gnt;
    int          exp_nst;
    int          exp_first;
    int          exp_last;
    int          exp_done_e;
    int          exp_idle_e;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock and sample just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Follow one burst; edge 1 is the first edge after req is driven.
  // Drops req when done is seen; optionally rewrites requester 0 config at edge 1.
  task automatic observe(input int limit, input bit chg, input logic [15:0] new_prd0,
                         input logic [7:0] new_len0,
                         output logic [1:0] gnt1, output logic busy1, output int nst,
                         output int first, output int last, output int done_e,
                         output logic [1:0] done_v, output int idle_e);
    gnt1 = '0; busy1 = 1'b0; nst = 0; first = 0; last = 0;
    done_e = 0; done_v = '0; idle_e = 0;
    for (int e = 1; e <= limit; e++) begin
      step();
      if (e == 1) begin
        gnt1  = gnt;
        busy1 = busy;
        if (chg) begin
          prd0 = new_prd0;
          len0 = new_len0;
        end
      end
      if (st) begin
        nst++;
        if (first == 0) first = e;
        last = e;
      end
      if (done != 2'b00 && done_e == 0) begin
        done_e = e;
        done_v = done;
        req    = 2'b00;
      end
      if (gnt == 2'b00) begin
        idle_e = e;
        break;
      end
    end
  endtask

  // Step until done pulses, bounded; returns 0 on timeout.
  task automatic wait_done(input int limit, output logic [1:0] d);
    d = '0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (done != 2'b00) begin
        d = done;
        break;
      end
    end
  endtask

  initial begin
    logic [1:0] g1, dv, d;
    logic       b1;
    int         nst, first, last, de, ie;
    int         ab_e;
    bit         saw_done;

    //            req    prd0   len0  prd1   len1  gnt    nst first last done idle
    vecs[0] = '{2'b01, 16'd4, 8'd3, 16'd0, 8'd0, 2'b01, 3, 5, 13, 14, 15};
    vecs[1] = '{2'b01, 16'd0, 8'd4, 16'd0, 8'd0, 2'b01, 4, 2, 5,  6,  7};
    vecs[2] = '{2'b10, 16'd0, 8'd0, 16'd3, 8'd1, 2'b10, 1, 4, 4,  5,  6};
    vecs[3] = '{2'b10, 16'd0, 8'd0, 16'd5, 8'd0, 2'b10, 0, 0, 0,  1,  2};
    vecs[4] = '{2'b01, 16'd1, 8'd2, 16'd0, 8'd0, 2'b01, 2, 2, 3,  4,  5};
    vecs[5] = '{2'b10, 16'd0, 8'd0, 16'd2, 8'd3, 2'b10, 3, 3, 7,  8,  9};

    rst = 1'b1; req = '0; prd0 = '0; prd1 = '0; len0 = '0; len1 = '0;
    #12;
    check("rst_gnt", gnt, 0);
    check("rst_st", st, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Table of isolated bursts.
    for (int i = 0; i < 6; i++) begin
      prd0 = vecs[i].prd0; len0 = vecs[i].len0;
      prd1 = vecs[i].prd1; len1 = vecs[i].len1;
      req  = vecs[i].req;
      observe(200, 1'b0, '0, '0, g1, b1, nst, first, last, de, dv, ie);
      check($sformatf("v%0d_gnt", i), g1, vecs[i].exp_gnt);
      check($sformatf("v%0d_busy", i), b1, 1);
      check($sformatf("v%0d_nst", i), nst, vecs[i].exp_nst);
      check($sformatf("v%0d_first_st", i), first, vecs[i].exp_first);
      check($sformatf("v%0d_last_st", i), last, vecs[i].exp_last);
      check($sformatf("v%0d_done_edge", i), de, vecs[i].exp_done_e);
      check($sformatf("v%0d_done_val", i), dv, vecs[i].exp_gnt);
      check($sformatf("v%0d_idle_edge", i), ie, vecs[i].exp_idle_e);
      req = '0;
      step();
      step();
    end

    // Contention from reset: 0 first, then 1, then 0 again.
    rst = 1'b1;
    prd0 = 16'd2; prd1 = 16'd2; len0 = 8'd2; len1 = 8'd2; req = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    step();
    check("cont_gnt_first", gnt, 2'b01);
    wait_done(50, d);
    check("cont_done_first", d, 2'b01);
    req = 2'b10;
    step();
    check("cont_idle_gap", gnt, 2'b00);
    step();
    check("cont_gnt_second", gnt, 2'b10);
    wait_done(50, d);
    check("cont_done_second", d, 2'b10);
    req = 2'b00;
    step();
    req = 2'b11;
    step();
    check("cont_gnt_rr_back", gnt, 2'b01);
    req = 2'b00;
    step();
    check("cont_abort_idle", gnt, 2'b00);
    step();

    // Abort after the second strobe.
    prd0 = 16'd10; len0 = 8'd5; req = 2'b01;
    nst = 0; ab_e = 0; ie = 0; saw_done = 1'b0;
    for (int e = 1; e <= 100; e++) begin
      step();
      if (st) nst++;
      if (done != 2'b00) saw_done = 1'b1;
      if (req == 2'b00 && gnt == 2'b00 && ie == 0) ie = e;
      if (nst == 2 && req != 2'b00) begin
        req  = 2'b00;
        ab_e = e;
      end
    end
    check("abort_strobes", nst, 2);
    check("abort_2nd_edge", ab_e, 21);
    check("abort_idle_edge", ie, 22);
    check("abort_no_done", saw_done, 0);
    check("abort_busy", busy, 0);

    // Reset asserted between edges while a strobe is high.
    prd0 = 16'd3; len0 = 8'd5; req = 2'b01;
    for (int e = 1; e <= 4; e++) step();
    check("mid_st_before_rst", st, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", {gnt, st, busy, done}, 0);
    prd0 = 16'd2; len0 = 8'd1; prd1 = 16'd2; len1 = 8'd1; req = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    step();
    check("mid_rst_regrant", gnt, 2'b01);
    wait_done(50, d);
    check("mid_rst_done", d, 2'b01);
    req = 2'b00;
    step();
    step();

    // Config change during RUN is ignored.
    prd0 = 16'd3; len0 = 8'd3; req = 2'b01;
    observe(200, 1'b1, 16'd7, 8'd9, g1, b1, nst, first, last, de, dv, ie);
    check("cfg_gnt", g1, 2'b01);
    check("cfg_nst", nst, 3);
    check("cfg_first_st", first, 4);
    check("cfg_last_st", last, 10);
    check("cfg_done_edge", de, 11);
    check("cfg_idle_edge", ie, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
